button_debounce_reader: RTL and testbench
=========================================

// Module: button_debounce_reader
// PURPOSE
//   Input-side counterpart to the LED counter outputs: samples a raw mechanical push-button pin,
//   synchronises and debounces it, and reports clean press/release/long-press events.
//   Also keeps a 4-bit press count that can drive the board LEDs directly.
//   Sits between a top-level pin and any user logic clocked by the 12 MHz board clock.
// PARAMETERS
//   DEBOUNCE_CYCLES  120000    clocks the synchronised input must stay stable to be accepted (10 ms @ 12 MHz)
//   LONG_CYCLES      12000000  clocks held, counted after press acceptance, before long_pulse fires (1 s)
//   ACTIVE_LOW       1         1: pin reads 0 when pressed; 0: pin reads 1 when pressed
//   CNT_W            24        timer width; must satisfy 2**CNT_W > max(DEBOUNCE_CYCLES, LONG_CYCLES)
// PORTS
//   clk            in   1  board clock, all logic on rising edge
//   rst_n          in   1  asynchronous reset, active low
//   btn_in         in   1  raw asynchronous button pin
//   btn_level      out  1  debounced level, 1 = pressed
//   press_pulse    out  1  one-cycle strobe when a press is accepted
//   release_pulse  out  1  one-cycle strobe when a release is accepted
//   long_pulse     out  1  one-cycle strobe, at most once per hold
//   press_count    out  4  accepted presses modulo 16
// BEHAVIOUR
//   - Reset: all outputs 0; synchroniser flops load the "released" pin level; FSM=IDLE; timer=0.
//   - Sync: 2-FF synchroniser, then polarity normalised to 1 = pressed (s_btn).
//   - FSM states: IDLE (stable released), DB_PRESS, HELD (stable pressed), DB_RELEASE.
//     IDLE: if s_btn=1 -> DB_PRESS, timer=0.
//     DB_PRESS: if s_btn=0 -> IDLE, timer=0, no pulse; else timer++. When timer==DEBOUNCE_CYCLES-1
//       with s_btn=1 -> HELD, timer=0, press_pulse=1 for one cycle, btn_level=1, press_count++.
//     HELD: if s_btn=0 -> DB_RELEASE, timer=0; else timer counts toward LONG_CYCLES-1 (see CONFIGURATION).
//     DB_RELEASE: if s_btn=1 -> HELD, timer=0, long_fired kept; else timer++. When timer==DEBOUNCE_CYCLES-1
//       with s_btn=0 -> IDLE, release_pulse=1 for one cycle, btn_level=0, long_fired cleared.
//   - Latency: a clean pin edge produces press_pulse/release_pulse exactly DEBOUNCE_CYCLES+2 clocks
//     after the first rising edge sampling the new pin level; btn_level changes on the same edge.
//   - A bounce (s_btn returning to the old level) before acceptance restarts qualification from 0; no events.
//   - press_count wraps 15 -> 0 silently. Pulses are mutually exclusive; never two in one cycle.
//   - All outputs are registered. No combinational path from btn_in to any output.
//   - rst_n asserted mid-debounce or mid-hold: immediate return to reset values; no pulse emitted
//     on reset entry or exit. A button already held at reset release is accepted as a fresh press
//     after qualification.
// CONFIGURATION
//   BTN_LONG_PRESS_EN defined: in HELD the timer increments; at timer==LONG_CYCLES-1 with long_fired=0,
//     long_pulse=1 for one cycle and long_fired=1. Timer saturates afterwards; at most one long_pulse per hold.
//   BTN_LONG_PRESS_EN undefined: long_pulse tied to 0, long_fired and the HELD timer increment are removed,
//     LONG_CYCLES is ignored, and the timer is sized for DEBOUNCE_CYCLES only.
// STRUCTURE
//   btn_pkg: FSM state typedef/encoding (IDLE=2'd0, DB_PRESS=2'd1, HELD=2'd2, DB_RELEASE=2'd3)
//     and the default cycle constants for the 12 MHz board clock.
//   Sub-module btn_sync: 2-FF synchroniser with reset value input; used here and by future pin readers.
//   Remainder (timer, FSM, counters) lives in button_debounce_reader.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, LONG_CYCLES=16, ACTIVE_LOW=1, macro defined unless stated)
//   1 Clean press: btn_in 1->0 held 30 clk -> press_pulse at clk 6, btn_level=1, press_count=1, no long_pulse.
//   2 Bounce: btn_in low 3 clk, high 2, low 20 -> one press_pulse, 6 clk after the final falling edge.
//   3 Long hold: btn_in low 40 clk -> press_pulse at 6, long_pulse exactly once at 6+16=22;
//     release -> release_pulse 6 clk later.
//   4 Wrap: 17 clean press/release pairs -> press_count=1, 17 press_pulse and 17 release_pulse.
//   5 Reset mid-hold: rst_n low at clk 10 of a hold -> all outputs 0 immediately; after rst_n high with
//     btn_in still low -> press_pulse 6 clk later.
//   6 Macro undefined: repeat test 3 -> long_pulse never asserts, all other responses identical.

Source files
------------

// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
//   Shared definitions for the push-button readers on the 12 MHz board:
//   the debounce FSM state encoding and the default cycle counts.
//   No ports (package).
// -----------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,  // stable released
        DB_PRESS   = 2'd1,  // qualifying a press
        HELD       = 2'd2,  // stable pressed
        DB_RELEASE = 2'd3   // qualifying a release
    } btn_state_t;

    // 10 ms and 1 s at the 12 MHz board clock
    localparam int unsigned DEBOUNCE_CYCLES_12MHZ = 120000;
    localparam int unsigned LONG_CYCLES_12MHZ     = 12000000;
    localparam int unsigned CNT_W_DEFAULT         = 24;

endpackage

// File: rtl/btn_sync.sv
// -----------------------------------------------------------------------------
// btn_sync
//   Two-flop synchroniser for a slow asynchronous pin. The reset value is an
//   input so each pin reader can preload its own idle level and not see a
//   spurious edge when reset is released.
// Ports
//   clk      in  1  sampling clock
//   rst_n    in  1  asynchronous reset, active low
//   rst_val  in  1  level both flops load during reset (tie to a constant)
//   d        in  1  raw asynchronous input
//   q        out 1  synchronised output, two clocks behind d
// -----------------------------------------------------------------------------
module btn_sync
    import btn_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= rst_val;
            sync_p1 <= rst_val;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/button_debounce_reader.sv
// -----------------------------------------------------------------------------
// button_debounce_reader
//   Synchronises and debounces a mechanical push-button pin and reports clean
//   press / release / long-press strobes plus a 4-bit press count suitable
//   for driving the board LEDs. All outputs are registered.
//
//   Optional feature macro: BTN_LONG_PRESS_EN
//     defined   : long_pulse fires once per hold, LONG_CYCLES clocks after the
//                 press was accepted.
//     undefined : long_pulse is tied low, LONG_CYCLES is ignored and the timer
//                 is only wide enough for DEBOUNCE_CYCLES.
//
// Ports
//   clk            in   1  board clock, rising edge
//   rst_n          in   1  asynchronous reset, active low
//   btn_in         in   1  raw asynchronous button pin
//   btn_level      out  1  debounced level, 1 = pressed
//   press_pulse    out  1  one-cycle strobe on accepted press
//   release_pulse  out  1  one-cycle strobe on accepted release
//   long_pulse     out  1  one-cycle strobe, at most once per hold
//   press_count    out  4  accepted presses modulo 16
// -----------------------------------------------------------------------------
module button_debounce_reader
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_12MHZ,
    parameter int unsigned LONG_CYCLES     = LONG_CYCLES_12MHZ,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [3:0] press_count
);

`ifdef BTN_LONG_PRESS_EN
    localparam int unsigned TIMER_W = CNT_W;
`else
    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES >= 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TIMER_W = (DB_W < CNT_W) ? DB_W : CNT_W;
`endif

    localparam logic [TIMER_W-1:0] DB_LAST = TIMER_W'(DEBOUNCE_CYCLES - 1);

    btn_state_t         state;
    btn_state_t         state_next;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_next;
    logic               pin_sync;
    logic               s_btn;
    logic               press_evt;
    logic               release_evt;
    logic               level_next;
    logic [3:0]         count_next;

    // The synchroniser idles at the released pin level so reset release never
    // looks like a press edge.
    btn_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rst_val (ACTIVE_LOW),
        .d       (btn_in),
        .q       (pin_sync)
    );

    assign s_btn = pin_sync ^ ACTIVE_LOW;

`ifdef BTN_LONG_PRESS_EN
    localparam logic [TIMER_W-1:0] LONG_LAST = TIMER_W'(LONG_CYCLES - 1);

    logic long_fired;
    logic long_fired_next;
    logic long_evt;
`else
    logic unused_long_cfg;
    assign unused_long_cfg = (LONG_CYCLES != 0);
`endif

    // State register plus registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= '0;
`ifdef BTN_LONG_PRESS_EN
            long_fired    <= 1'b0;
            long_pulse    <= 1'b0;
`endif
        end else begin
            state         <= state_next;
            timer         <= timer_next;
            btn_level     <= level_next;
            press_pulse   <= press_evt;
            release_pulse <= release_evt;
            press_count   <= count_next;
`ifdef BTN_LONG_PRESS_EN
            long_fired    <= long_fired_next;
            long_pulse    <= long_evt;
`endif
        end
    end

`ifndef BTN_LONG_PRESS_EN
    assign long_pulse = 1'b0;
`endif

    // Next-state logic. Any bounce back to the old level during qualification
    // abandons it; qualification then restarts from zero on the next change.
    always_comb begin
        state_next      = state;
        timer_next      = timer;
        press_evt       = 1'b0;
        release_evt     = 1'b0;
`ifdef BTN_LONG_PRESS_EN
        long_fired_next = long_fired;
        long_evt        = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (s_btn) begin
                    state_next = DB_PRESS;
                    timer_next = '0;
                end
            end
            DB_PRESS: begin
                if (!s_btn) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (timer == DB_LAST) begin
                    state_next = HELD;
                    timer_next = '0;
                    press_evt  = 1'b1;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            HELD: begin
                if (!s_btn) begin
                    state_next = DB_RELEASE;
                    timer_next = '0;
                end
`ifdef BTN_LONG_PRESS_EN
                // Timer parks at LONG_LAST; long_fired keeps it to one strobe.
                else if (timer == LONG_LAST) begin
                    if (!long_fired) begin
                        long_evt        = 1'b1;
                        long_fired_next = 1'b1;
                    end
                end else begin
                    timer_next = timer + 1'b1;
                end
`endif
            end
            DB_RELEASE: begin
                if (s_btn) begin
                    // Release bounce: still the same hold, so long_fired stays.
                    state_next = HELD;
                    timer_next = '0;
                end else if (timer == DB_LAST) begin
                    state_next      = IDLE;
                    timer_next      = '0;
                    release_evt     = 1'b1;
`ifdef BTN_LONG_PRESS_EN
                    long_fired_next = 1'b0;
`endif
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
        endcase
    end

    // Output logic: level and count follow the accepted events.
    always_comb begin
        level_next = btn_level;
        count_next = press_count;
        if (press_evt) begin
            level_next = 1'b1;
            count_next = press_count + 4'd1;
        end
        if (release_evt) begin
            level_next = 1'b0;
        end
    end

endmodule

// File: tb/tb_button_debounce_reader.sv
// -----------------------------------------------------------------------------
// tb_button_debounce_reader
//   Directed bench for button_debounce_reader with DEBOUNCE_CYCLES=4,
//   LONG_CYCLES=16, ACTIVE_LOW=1. Long-press expectations follow whether
//   BTN_LONG_PRESS_EN is defined for the build.
//   The reference model works on run lengths of the synchronised level: a new
//   level is accepted once it has been seen on DEBOUNCE_CYCLES+1 consecutive
//   edges, and a long press after LONG_CYCLES further pressed edges.
// -----------------------------------------------------------------------------
module tb_button_debounce_reader;

    localparam int D = 4;
    localparam int L = 16;
`ifdef BTN_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       btn_in = 1'b1;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [3:0] press_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int n_press = 0;
    int n_rel   = 0;
    int n_long  = 0;
    int last_press = -1;
    int last_rel   = -1;
    int last_long  = -1;

    button_debounce_reader #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .ACTIVE_LOW      (1'b1),
        .CNT_W           (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural model ----------------
    bit       m_p0 = 1'b1;
    bit       m_p1 = 1'b1;
    bit       s;
    bit       acc  = 1'b0;
    int       run  = 0;
    int       hc   = 0;
    bit       fired = 1'b0;
    bit       m_press = 1'b0;
    bit       m_rel   = 1'b0;
    bit       m_long  = 1'b0;
    bit [3:0] m_cnt   = 4'd0;

    task automatic model_reset();
        m_p0 = 1'b1; m_p1 = 1'b1; acc = 1'b0; run = 0; hc = 0; fired = 1'b0;
        m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0; m_cnt = 4'd0;
    endtask

    task automatic model_step();
        // level seen by the debouncer: pin delayed two edges, 1 = pressed
        s = ~m_p1;
        m_p1 = m_p0;
        m_p0 = btn_in;
        m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
        if (acc) begin
            if (s) begin
                if (hc <= L) hc++;
                if (hc == L && !fired && LONG_EN) begin
                    m_long = 1'b1;
                    fired  = 1'b1;
                end
            end else begin
                hc = -1;
            end
        end
        if (s != acc) begin
            run++;
            if (run == D + 1) begin
                run = 0;
                acc = s;
                if (s) begin
                    m_press = 1'b1;
                    m_cnt   = m_cnt + 4'd1;
                    hc      = 0;
                end else begin
                    m_rel = 1'b1;
                    fired = 1'b0;
                end
            end
        end else begin
            run = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        chk("level",   {31'd0, btn_level},     {31'd0, acc});
        chk("press",   {31'd0, press_pulse},   {31'd0, m_press});
        chk("release", {31'd0, release_pulse}, {31'd0, m_rel});
        chk("long",    {31'd0, long_pulse},    {31'd0, m_long});
        chk("count",   {28'd0, press_count},   {28'd0, m_cnt});
        if (press_pulse === 1'b1)   begin n_press++; last_press = cyc; end
        if (release_pulse === 1'b1) begin n_rel++;   last_rel   = cyc; end
        if (long_pulse === 1'b1)    begin n_long++;  last_long  = cyc; end
    end

    // Each step ends 1 time unit after a rising edge; inputs change there.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int k;
    int np;
    int nr;
    int nl;

    // A pin change made after edge k is first sampled at edge k+1 and the
    // strobe is registered at edge k+1+D+2 = k+7.
    initial begin
        rst_n = 1'b0;
        btn_in = 1'b1;
        step(3);
        chk("rst_level", {31'd0, btn_level}, 32'd0);
        chk("rst_press", {31'd0, press_pulse}, 32'd0);
        chk("rst_count", {28'd0, press_count}, 32'd0);
        rst_n = 1'b1;
        step(3);

        // clean press and release
        k = cyc; np = n_press; nl = n_long;
        btn_in = 1'b0;
        step(20);
        chk("t1_press_at", last_press - k, 32'd7);
        chk("t1_npress", n_press - np, 32'd1);
        chk("t1_count", {28'd0, press_count}, 32'd1);
        chk("t1_level", {31'd0, btn_level}, 32'd1);
        chk("t1_nlong", n_long - nl, 32'd0);
        k = cyc;
        btn_in = 1'b1;
        step(10);
        chk("t1_release_at", last_rel - k, 32'd7);
        chk("t1_level_off", {31'd0, btn_level}, 32'd0);

        // bounce: low 3, high 2, low 20
        np = n_press;
        btn_in = 1'b0; step(3);
        btn_in = 1'b1; step(2);
        k = cyc;
        btn_in = 1'b0; step(20);
        chk("t2_press_at", last_press - k, 32'd7);
        chk("t2_npress", n_press - np, 32'd1);
        chk("t2_count", {28'd0, press_count}, 32'd2);
        btn_in = 1'b1; step(10);

        // long hold
        k = cyc; nl = n_long;
        btn_in = 1'b0; step(40);
        chk("t3_press_at", last_press - k, 32'd7);
        if (LONG_EN) begin
            chk("t3_long_at", last_long - k, 32'd23);
            chk("t3_nlong", n_long - nl, 32'd1);
        end else begin
            chk("t3_nlong", n_long - nl, 32'd0);
        end
        k = cyc;
        btn_in = 1'b1; step(10);
        chk("t3_release_at", last_rel - k, 32'd7);

        // counter wrap after a fresh reset
        rst_n = 1'b0; step(2);
        rst_n = 1'b1; step(2);
        np = n_press; nr = n_rel;
        for (int i = 0; i < 17; i++) begin
            btn_in = 1'b0; step(8);
            btn_in = 1'b1; step(8);
        end
        chk("t4_count", {28'd0, press_count}, 32'd1);
        chk("t4_npress", n_press - np, 32'd17);
        chk("t4_nrel", n_rel - nr, 32'd17);

        // reset mid-hold, button still down at reset release
        btn_in = 1'b0; step(10);
        chk("t5_level_before", {31'd0, btn_level}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_level", {31'd0, btn_level}, 32'd0);
        chk("t5_rst_count", {28'd0, press_count}, 32'd0);
        chk("t5_rst_pulses", {29'd0, press_pulse, release_pulse, long_pulse}, 32'd0);
        step(3);
        k = cyc; np = n_press;
        rst_n = 1'b1;
        step(12);
        chk("t5_press_at", last_press - k, 32'd7);
        chk("t5_npress", n_press - np, 32'd1);
        chk("t5_count", {28'd0, press_count}, 32'd1);
        btn_in = 1'b1; step(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
